// File: rtl/hilo_divider_if.sv
// Issue/move/result bundle between the MIPS datapath and the HI/LO divide unit.
// The datapath drives through master; the divider sits on slave.
interface hilo_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, dividend, divisor, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, dividend, divisor, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, owning the MIPS HI/LO
// registers: quotient to LO, remainder to HI, plus mthi/mtlo writes while idle.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  hilo_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] dvs;
  logic             qsign;
  logic             rsign;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   rsh;
  logic [WIDTH-1:0] rdiff;
  logic             take;

  // -2^(WIDTH-1) negates to its own bit pattern, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    sgn);
    if (sgn && (v < 0)) return WIDTH'(-v);
    return WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  // Partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
  always_comb begin
    rsh   = {r, q[WIDTH-1]};
    take  = (rsh >= {1'b0, dvs});
    rdiff = rsh[WIDTH-1:0] - dvs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
            cnt    <= CW'(WIDTH);
            q      <= magnitude(bus.dividend, bus.is_signed);
            dvs    <= magnitude(bus.divisor, bus.is_signed);
            r      <= '0;
            qsign  <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            rsign  <= bus.is_signed & bus.dividend[WIDTH-1];
          end else begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          q   <= {q[WIDTH-2:0], take};
          r   <= take ? rdiff : rsh[WIDTH-1:0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= FINISH;
            done_q <= 1'b1;
          end
        end
        FINISH: begin
          // Divide by zero leaves q all ones unnegated; re-signing the remainder restores the dividend.
          lo_q   <= apply_sign(q, qsign && (dvs != '0));
          hi_q   <= apply_sign(r, rsign);
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
